// File: rtl/enc_pkg.sv
// Shared types and constants for the mask encoder/serializer.
package enc_pkg;

  // Register count (mask width); must stay a power of two.
  localparam int unsigned N = 32;
  // Index width, derived from N.
  localparam int unsigned W = $clog2(N);

  typedef logic [N-1:0] mask_t;
  typedef logic [W-1:0] idx_t;

  typedef enum logic {
    IDLE,
    BUSY
  } enc_state_t;

endpackage

// File: rtl/decoder5x32.sv
// 5-to-32 one-hot decoder with enable; output is all zeros when disabled.
module decoder5x32
  import enc_pkg::*;
(
  input  idx_t  idx,
  input  logic  en,
  output mask_t onehot
);

  // Shift a single bit into place only while enabled.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot = mask_t'(1) << idx;
    end
  end

endmodule

// File: rtl/priority_encoder32x5.sv
// Combinational lowest-index-wins priority encoder: 32-bit mask to 5-bit index.
// idx is 0 when no bit is set; any flags a non-empty mask.
module priority_encoder32x5
  import enc_pkg::*;
(
  input  mask_t mask,
  output idx_t  idx,
  output logic  any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = idx_t'(i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/mask_encoder_serializer.sv
// Serializes a multi-hot register mask into a stream of set-bit indices, lowest first,
// one per cycle, with valid/ready on both sides.
// Optional feature: define ENC_SERIALIZER_ONEHOT_EN to add out_onehot, the one-hot
// decode of out_idx gated by out_valid.
module mask_encoder_serializer
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last
`ifdef ENC_SERIALIZER_ONEHOT_EN
  ,
  output logic [N-1:0] out_onehot
`endif
);

  enc_state_t state;
  mask_t      rem;
  idx_t       pe_idx;
  logic       pe_any;
  logic       one_left;

  priority_encoder32x5 u_prienc (
    .mask (rem),
    .idx  (pe_idx),
    .any  (pe_any)
  );

  // Exactly one bit remaining: non-empty and clearing the lowest set bit leaves nothing.
  always_comb begin
    one_left = pe_any && ((rem & (rem - mask_t'(1))) == '0);
  end

  // Outputs derive only from registered state and rem, never from in_* directly.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == BUSY);
    out_idx   = out_valid ? pe_idx : '0;
    out_last  = out_valid && one_left;
  end

`ifdef ENC_SERIALIZER_ONEHOT_EN
  decoder5x32 u_dec (
    .idx    (out_idx),
    .en     (out_valid),
    .onehot (out_onehot)
  );
`endif

  // FSM and remaining-bits register; a zero mask completes its handshake without output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && (in_mask != '0)) begin
            rem   <= in_mask;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (out_ready) begin
            rem <= rem & ~(mask_t'(1) << pe_idx);
            if (one_left) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          rem   <= '0;
        end
      endcase
    end
  end

endmodule
